// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite encodings, response codes and the SRAM slave FSM states.
// Contents: htrans_e, hsize_e, hburst_e, HRESP_OKAY/HRESP_ERROR, slv_state_e.
package ahbl_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'd0,
      HSIZE_HALF  = 3'd1,
      HSIZE_WORD  = 3'd2,
      HSIZE_DWORD = 3'd3,
      HSIZE_4W    = 3'd4,
      HSIZE_8W    = 3'd5,
      HSIZE_16W   = 3'd6,
      HSIZE_32W   = 3'd7
   } hsize_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } slv_state_e;

endpackage

// File: rtl/ahbl_sram_bytemask.sv
// ahbl_sram_bytemask: HSIZE + address low bits -> little-endian byte-lane write mask.
// Ports: hsize (transfer size), addr_lo (byte offset within the data word), mask (one bit per lane).
// Oversize transfers are clamped to the full bus width and misaligned offsets are
// rounded down to the transfer size, so the mask is always a legal aligned lane group.
module ahbl_sram_bytemask
   import ahbl_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   localparam int NB         = DATA_WIDTH / 8,
   localparam int LB         = $clog2(NB)
) (
   input  hsize_e          hsize,
   input  logic [LB-1:0]   addr_lo,
   output logic [NB-1:0]   mask
);

   logic [31:0] sz, nb, off;

   always_comb begin
      sz   = (32'(hsize) > 32'(LB)) ? 32'(LB) : 32'(hsize);
      nb   = 32'd1 << sz;
      off  = 32'(addr_lo) & ~(nb - 32'd1);
      mask = NB'(((32'd1 << nb) - 32'd1) << off);
   end

endmodule

// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave: AHB-Lite slave backed by a word-organised register-array memory.
// Ports: HCLK/HRESET (async active-high), AHB-Lite address phase (HSEL, HADDR, HTRANS,
// HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HREADY), data phase (HWDATA in, HRDATA,
// HREADYOUT, HRESP out).
// Configuration: define AHBL_SRAM_ERR_EN to answer out-of-range, oversize and misaligned
// transfers with a two-cycle ERROR; otherwise HRESP is always OKAY, the index wraps modulo
// MEM_DEPTH, oversize is treated as full width and misaligned addresses are aligned down.
module ahbl_sram_slave
   import ahbl_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic                  HMASTLOCK,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = $clog2(MEM_DEPTH);

   slv_state_e            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [LB-1:0]         off_q, off_d;
   hsize_e                size_q, size_d;
   logic                  write_q, write_d;
   logic                  accept, err, we;
   logic [NB-1:0]         lane_mask;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic                  unused_inputs;

   assign unused_inputs = ^{HADDR, HTRANS[0], HBURST, HPROT, HMASTLOCK};

   assign accept = HSEL && HREADY && HTRANS[1];

`ifdef AHBL_SRAM_ERR_EN
   assign err = (64'(HADDR) >= 64'(MEM_DEPTH) * 64'(NB))
             || (32'(HSIZE) > 32'(LB))
             || ((64'(HADDR) & ((64'd1 << HSIZE) - 64'd1)) != 64'd0);
   assign HRESP = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
   assign err   = 1'b0;
   assign HRESP = HRESP_OKAY;
`endif

   // WAIT and ERR1 are the only states that stall the bus; a new address phase can
   // only be taken from a state that drives HREADYOUT high.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      off_d   = off_q;
      size_d  = size_q;
      write_d = write_q;
      if (state_q == ST_WAIT) begin
         cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
         if (cnt_q <= 4'd1) state_d = ST_DATA;
      end else if (state_q == ST_ERR1) begin
         state_d = ST_ERR2;
      end else if (accept) begin
         idx_d   = HADDR[IW+LB-1:LB];
         off_d   = HADDR[LB-1:0];
         size_d  = hsize_e'(HSIZE);
         write_d = HWRITE;
         cnt_d   = err ? 4'd0 : 4'(WAIT_STATES);
         state_d = err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);
      end else begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         off_q   <= '0;
         size_q  <= HSIZE_BYTE;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         size_q  <= size_d;
         write_q <= write_d;
      end
   end

   ahbl_sram_bytemask #(.DATA_WIDTH(DATA_WIDTH)) u_bytemask (
      .hsize   (size_q),
      .addr_lo (off_q),
      .mask    (lane_mask)
   );

   // The write lands on the edge that closes the DATA cycle, so a read whose data
   // phase immediately follows already sees the new word.
   assign we = (state_q == ST_DATA) && write_q;

   always_ff @(posedge HCLK) begin
      for (int b = 0; b < NB; b++)
         if (we && lane_mask[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
   end

   assign HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
   assign HRDATA    = (state_q == ST_DATA && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// tb_ahbl_sram_slave: self-checking bench for ahbl_sram_slave with a zero-wait and a three-wait instance.
`timescale 1ns/1ps
module tb_ahbl_sram_slave;

`ifdef AHBL_SRAM_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic             clk, rst;
   logic [1:0]       hsel, ho, hp;
   logic [31:0]      haddr, hwdata;
   logic [1:0]       htrans;
   logic             hwrite;
   logic [2:0]       hsize, hburst;
   logic [1:0][31:0] hr;
   int               n_cmp, n_bad;
   logic [7:0]       mdl [2][4096];

   typedef struct {
      bit          wr;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [31:0] wd;
      logic [31:0] rd;
      bit          err;
   } vec_t;
   vec_t tv [11];

   ahbl_sram_slave #(.WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(4'h3), .HMASTLOCK(1'b0),
      .HWDATA(hwdata), .HREADY(ho[0]), .HRDATA(hr[0]), .HREADYOUT(ho[0]), .HRESP(hp[0])
   );

   ahbl_sram_slave #(.WAIT_STATES(3)) dut1 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(4'h3), .HMASTLOCK(1'b0),
      .HWDATA(hwdata), .HREADY(ho[1]), .HRDATA(hr[1]), .HREADYOUT(ho[1]), .HRESP(hp[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mread(input int k, input logic [31:0] a);
      int b;
      b = int'(a & 32'hFFC);
      return {mdl[k][b+3], mdl[k][b+2], mdl[k][b+1], mdl[k][b]};
   endfunction

   function automatic void mwrite(input int k, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
      int n, b;
      n = 1 << ((sz > 3'd2) ? 2 : int'(sz));
      b = int'(a & 32'hFFF) & ~(n - 1);
      for (int i = 0; i < n; i++) mdl[k][b+i] = wd[8*((b+i)%4) +: 8];
   endfunction

   function automatic bit merr(input logic [31:0] a, input logic [2:0] sz);
`ifdef AHBL_SRAM_ERR_EN
      return a >= 32'd4096 || sz > 3'd2 || (a % (32'd1 << sz)) != 32'd0;
`else
      return (^{a, sz}) & 1'b0;
`endif
   endfunction

   task automatic bus_idle();
      hsel = '0; htrans = 2'b00; hwrite = 1'b0; hburst = 3'd0;
   endtask

   task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output logic rp,
                       output logic first, output int lows);
      @(posedge clk); #1;
      hsel = '0; hsel[k] = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
      @(posedge clk); #1;
      bus_idle();
      hwdata = wd;
      lows = 0;
      @(negedge clk);
      first = hp[k];
      while (!ho[k] && lows < 40) begin
         lows++;
         @(negedge clk);
      end
      rd = hr[k];
      rp = hp[k];
   endtask

   task automatic op(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input string tag);
      logic [31:0] rd, exp;
      logic        rp, first;
      int          lows;
      bit          e;
      e   = merr(a, sz);
      exp = (wr || e) ? 32'h0 : mread(k, a);
      xfer(k, wr, a, sz, wd, rd, rp, first, lows);
      chk({tag, " resp"}, 32'(rp), 32'(e));
      chk({tag, " first-cycle resp"}, 32'(first), 32'(e));
      chk({tag, " waits"}, 32'(lows), e ? 32'd1 : (k == 1 ? 32'd3 : 32'd0));
      chk({tag, " rdata"}, rd, exp);
      if (wr && !e) mwrite(k, a, sz, wd);
   endtask

   initial begin
      logic [31:0] rd, a;
      logic        rp, first;
      int          lows, total, k;
      rst = 1'b1;
      hwdata = '0; haddr = '0; hsize = 3'd2;
      bus_idle();
      n_cmp = 0; n_bad = 0;

      tv[0]  = '{1'b1, 32'h40,   3'd1 + 3'd1, 32'h12345678, 32'h0, 1'b0};
      tv[1]  = '{1'b0, 32'h40,   3'd2, 32'h0,         32'h12345678, 1'b0};
      tv[2]  = '{1'b1, 32'h41,   3'd0, 32'h0000AB00,  32'h0, 1'b0};
      tv[3]  = '{1'b0, 32'h40,   3'd2, 32'h0,         32'h1234AB78, 1'b0};
      tv[4]  = '{1'b1, 32'h42,   3'd1, 32'hCDEF0000,  32'h0, 1'b0};
      tv[5]  = '{1'b0, 32'h40,   3'd2, 32'h0,         32'hCDEFAB78, 1'b0};
      tv[6]  = '{1'b1, 32'h0,    3'd2, 32'h11112222,  32'h0, 1'b0};
      tv[7]  = '{1'b1, 32'h1000, 3'd2, 32'hA5A5A5A5,  32'h0, ERR};
      tv[8]  = '{1'b0, 32'h0,    3'd2, 32'h0,         ERR ? 32'h11112222 : 32'hA5A5A5A5, 1'b0};
      tv[9]  = '{1'b1, 32'h3,    3'd1, 32'hBEEF0000,  32'h0, ERR};
      tv[10] = '{1'b0, 32'h0,    3'd2, 32'h0,         ERR ? 32'h11112222 : 32'hBEEFA5A5, 1'b0};

      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset ready%0d", i), 32'(ho[i]), 32'h1);
         chk($sformatf("reset resp%0d", i), 32'(hp[i]), 32'h0);
         chk($sformatf("reset rdata%0d", i), hr[i], 32'h0);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int w = 0; w < 64; w++)
         for (int j = 0; j < 2; j++) op(j, 1'b1, 32'(4 * w), 3'd2, $urandom, "preload");

      for (int i = 0; i < 11; i++) begin
         xfer(0, tv[i].wr, tv[i].a, tv[i].sz, tv[i].wd, rd, rp, first, lows);
         chk($sformatf("tv%0d resp", i), 32'(rp), 32'(tv[i].err));
         chk($sformatf("tv%0d waits", i), 32'(lows), 32'(tv[i].err));
         chk($sformatf("tv%0d rdata", i), rd, tv[i].rd);
         if (tv[i].wr && !tv[i].err) mwrite(0, tv[i].a, tv[i].sz, tv[i].wd);
      end

      // back-to-back write then read of the same word on the zero-wait slave
      @(posedge clk); #1;
      hsel = 2'b01; htrans = 2'b10; haddr = 32'h44; hwrite = 1'b1; hsize = 3'd2;
      @(posedge clk); #1;
      hwrite = 1'b0; hwdata = 32'h87654321;
      @(negedge clk);
      chk("b2b write ready", 32'(ho[0]), 32'h1);
      @(posedge clk); #1;
      bus_idle();
      @(negedge clk);
      chk("b2b read data", hr[0], 32'h87654321);
      chk("b2b read resp", 32'(hp[0]), 32'h0);
      mwrite(0, 32'h44, 3'd2, 32'h87654321);

      // reset in the middle of a zero-wait read data phase
      op(0, 1'b1, 32'h10, 3'd2, 32'h0BADF00D, "pre-reset write0");
      @(posedge clk); #1;
      hsel = 2'b01; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b0;
      @(posedge clk); #1;
      bus_idle();
      @(negedge clk);
      chk("rst0 rdata before", hr[0], 32'h0BADF00D);
      rst = 1'b1; #1;
      chk("rst0 ready", 32'(ho[0]), 32'h1);
      chk("rst0 resp", 32'(hp[0]), 32'h0);
      chk("rst0 rdata", hr[0], 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // reset while the wait-state slave is stalling a write of 0xDEADBEEF
      op(1, 1'b1, 32'h10, 3'd2, 32'h5EED1234, "pre-reset write1");
      @(posedge clk); #1;
      hsel = 2'b10; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
      @(posedge clk); #1;
      bus_idle();
      hwdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("rst1 stalled", 32'(ho[1]), 32'h0);
      rst = 1'b1; #1;
      chk("rst1 ready", 32'(ho[1]), 32'h1);
      chk("rst1 resp", 32'(hp[1]), 32'h0);
      chk("rst1 rdata", hr[1], 32'h0);
      @(negedge clk);
      rst = 1'b0;
      op(1, 1'b0, 32'h10, 3'd2, 32'h0, "post-reset read1");
      op(0, 1'b0, 32'h10, 3'd2, 32'h0, "post-reset read0");

      // INCR4 read burst from 0x80 on the three-wait slave
      total = 0;
      @(posedge clk); #1;
      hsel = 2'b10; htrans = 2'b10; haddr = 32'h80; hwrite = 1'b0; hsize = 3'd2; hburst = 3'd3;
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++) begin
         if (b < 3) begin
            htrans = 2'b11; haddr = 32'h80 + 32'(4 * (b + 1));
         end else bus_idle();
         lows = 0;
         @(negedge clk);
         while (!ho[1] && lows < 40) begin
            lows++; total++;
            @(negedge clk);
         end
         total++;
         chk($sformatf("incr4 beat%0d waits", b), 32'(lows), 32'd3);
         chk($sformatf("incr4 beat%0d data", b), hr[1], mread(1, 32'h80 + 32'(4 * b)));
         chk($sformatf("incr4 beat%0d resp", b), 32'(hp[1]), 32'h0);
         @(posedge clk); #1;
      end
      chk("incr4 total cycles", 32'(total), 32'd16);

      for (int i = 0; i < 240; i++) begin
         k = i % 2;
         a = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) a = a + 32'h1000 * 32'($urandom_range(1, 3));
         op(k, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 3)), $urandom, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
